axonerve_kvs_batch_sequencer: RTL and testbench
===============================================

Name: axonerve_kvs_batch_sequencer

Overview:
- Top-level sequencer for the KVS global-memory datapath.
- Splits one host transfer (ap_start) into fixed-size chunks. For each chunk it drives the ctrl_start, address offset and size of the AXI read master and the AXI write master, waits for both done pulses, then advances.
- Produces ap_done, ap_idle and status counters.
- Sits between the kernel control registers and the two AXI master ctrl interfaces. The user-logic stream path is untouched.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, address width of all offsets.
- C_M_AXI_DATA_WIDTH, 512, AXI data width. Sets alignment LP_DW_BYTES = C_M_AXI_DATA_WIDTH/8.
- C_XFER_SIZE_WIDTH, 32, width of all byte counts.
- C_TIMEOUT_WIDTH, 32, width of the per-chunk watchdog counter.

Ports:
- aclk  in  1  single clock.
- aresetn  in  1  synchronous, active-low reset.
- ap_start  in  1  start request; sampled only in IDLE.
- ap_done  out  1  one-cycle completion pulse.
- ap_idle  out  1  high while in IDLE.
- ctrl_src_addr  in  C_M_AXI_ADDR_WIDTH  read base address.
- ctrl_dst_addr  in  C_M_AXI_ADDR_WIDTH  write base address.
- ctrl_total_bytes  in  C_XFER_SIZE_WIDTH  total transfer size.
- ctrl_chunk_bytes  in  C_XFER_SIZE_WIDTH  chunk size; 0 means a single chunk.
- ctrl_timeout_cycles  in  C_TIMEOUT_WIDTH  per-chunk watchdog limit; 0 disables it.
- rd_ctrl_start  out  1  read master start pulse.
- rd_ctrl_addr_offset  out  C_M_AXI_ADDR_WIDTH  read chunk address.
- rd_ctrl_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  read chunk size.
- rd_ctrl_done  in  1  read master done pulse.
- wr_ctrl_start  out  1  write master start pulse.
- wr_ctrl_addr_offset  out  C_M_AXI_ADDR_WIDTH  write chunk address.
- wr_ctrl_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  write chunk size.
- wr_ctrl_done  in  1  write master done pulse.
- stat_chunks_done  out  32  chunks completed in the current or last run.
- stat_timeout  out  1  sticky: last run aborted by the watchdog.
- stat_error  out  1  sticky: last run rejected for misalignment.

Behaviour:
- Reset values: every output 0, except ap_idle=1. State is IDLE. All internal registers and flags are cleared.
- Reset mid-run: all outputs return to their reset values on the next edge. No ap_done is generated.
- States: IDLE, LOAD, ISSUE, WAIT, NEXT, DONE.
- IDLE, ap_start=1 at cycle T:
  - Latch all ctrl_* inputs.
  - Clear stat_* registers.
  - Go to LOAD.
  - ap_idle goes low at T+1.
- LOAD:
  - If total or chunk is not a multiple of LP_DW_BYTES: set stat_error, go to DONE.
  - Else if total==0: go to DONE.
  - Else: remaining=total, offset=0, go to ISSUE.
- ISSUE (first occurrence at T+2), single cycle:
  - Chunk size = min(chunk, remaining); chunk==0 means size = remaining.
  - rd_ctrl_start and wr_ctrl_start are both high for exactly this cycle.
  - rd addr = src+offset, wr addr = dst+offset, both modulo 2^C_M_AXI_ADDR_WIDTH.
  - Sizes are driven together with the addresses.
  - All address and size outputs hold stable until the next ISSUE.
  - Go to WAIT.
- WAIT:
  - Sticky flags rd_seen and wr_seen capture the done pulses in either order. Both in the same cycle is legal.
  - When both flags are set (sampled at cycle D): clear the flags and the watchdog, go to NEXT.
  - Watchdog counts cycles spent in WAIT. If ctrl_timeout_cycles!=0 and the count reaches it: set stat_timeout, go to DONE.
  - If done and timeout coincide, done wins.
- NEXT (D+1):
  - remaining -= size; offset += size; stat_chunks_done += 1.
  - If remaining==0, go to DONE; else go to ISSUE.
- DONE: ap_done high for one cycle, then IDLE. ap_idle is high from the following cycle.
- Ignored inputs:
  - ap_start outside IDLE.
  - Done pulses outside WAIT.
  - ctrl_* changes after LOAD.
- The last chunk may be smaller than ctrl_chunk_bytes. It is never zero.

Test Plan:
- Single chunk: src=0x1000, dst=0x8000, total=4096, chunk=0. → One start pair at T+2, addrs 0x1000/0x8000, size 4096. Both dones at T+10 → ap_done at T+12, stat_chunks_done=1.
- Multi-chunk: total=10240, chunk=4096, src=0. → Three ISSUE pulses with sizes 4096, 4096, 2048 and read addrs 0x0, 0x1000, 0x2000. stat_chunks_done=3.
- Done ordering:
  - wr_done 5 cycles before rd_done → NEXT one cycle after rd_done.
  - Both done in the same cycle → NEXT next cycle.
  - Stray done pulse in IDLE → no effect.
- Zero and misalignment:
  - total=0 → ap_done at T+2, no start pulses.
  - total=100 → ap_done at T+2, stat_error=1, no start pulses.
- Watchdog: timeout=50, withhold rd_done → stat_timeout=1, ap_done 50 cycles after entering WAIT. A following clean run clears stat_timeout.
- Reset: assert aresetn=0 during WAIT of chunk 2 → outputs at reset values, ap_idle=1, no ap_done. A new ap_start then runs normally.

Source files
------------

// File: rtl/axonerve_kvs_batch_sequencer_if.sv
// Control bundle between the batch sequencer and one AXI master.
// The sequencer drives start/offset/size and receives the done pulse.
interface axonerve_kvs_batch_sequencer_if #(
   parameter int ADDR_W = 64,
   parameter int SIZE_W = 32
);
   logic              start;
   logic [ADDR_W-1:0] addr_offset;
   logic [SIZE_W-1:0] xfer_size_in_bytes;
   logic              done;

   modport master (
      output start,
      output addr_offset,
      output xfer_size_in_bytes,
      input  done
   );

   modport slave (
      input  start,
      input  addr_offset,
      input  xfer_size_in_bytes,
      output done
   );
endinterface

// File: rtl/axonerve_kvs_batch_sequencer.sv
// Splits one host transfer into chunks and runs the AXI read and write
// masters in lockstep, one chunk at a time, with a per-chunk watchdog.
module axonerve_kvs_batch_sequencer #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int C_TIMEOUT_WIDTH    = 32
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          ap_start,
   output logic                          ap_done,
   output logic                          ap_idle,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_src_addr,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_dst_addr,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_total_bytes,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_chunk_bytes,
   input  logic [C_TIMEOUT_WIDTH-1:0]    ctrl_timeout_cycles,
   axonerve_kvs_batch_sequencer_if.master rd_ctrl,
   axonerve_kvs_batch_sequencer_if.master wr_ctrl,
   output logic [31:0]                   stat_chunks_done,
   output logic                          stat_timeout,
   output logic                          stat_error
);

   localparam int LP_DW_BYTES = C_M_AXI_DATA_WIDTH / 8;

   typedef logic [C_M_AXI_ADDR_WIDTH-1:0] addr_t;
   typedef logic [C_XFER_SIZE_WIDTH-1:0]  size_t;
   typedef logic [C_TIMEOUT_WIDTH-1:0]    tmo_t;

   localparam size_t LP_ALIGN_MASK = size_t'(LP_DW_BYTES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0] state_q;

   addr_t src_q;
   addr_t dst_q;
   size_t total_q;
   size_t chunk_q;
   tmo_t  tmo_q;

   size_t rem_q;
   addr_t off_q;
   addr_t rd_addr_q;
   addr_t wr_addr_q;
   size_t size_q;

   tmo_t  wd_q;
   logic  rd_seen_q;
   logic  wr_seen_q;

   logic [31:0] chunks_q;
   logic        timeout_q;
   logic        error_q;

   logic  rd_hit;
   logic  wr_hit;
   logic  both_done;
   tmo_t  wd_inc;
   logic  wd_fire;
   logic  misaligned;
   size_t rem_nxt;
   addr_t off_nxt;

   // Zero chunk size means "whole remainder in one go".
   function automatic size_t chunk_size(
      input size_t chunk,
      input size_t rem
   );
      if (chunk == '0 || chunk > rem)
         return rem;
      return chunk;
   endfunction

   // A done pulse in the current cycle counts as already seen.
   always_comb begin
      rd_hit     = rd_seen_q | rd_ctrl.done;
      wr_hit     = wr_seen_q | wr_ctrl.done;
      both_done  = rd_hit & wr_hit;
      wd_inc     = wd_q + tmo_t'(1);
      wd_fire    = (tmo_q != '0) && (wd_inc == tmo_q);
      misaligned = ((total_q & LP_ALIGN_MASK) != '0)
                 || ((chunk_q & LP_ALIGN_MASK) != '0);
      rem_nxt    = rem_q - size_q;
      off_nxt    = off_q + addr_t'(size_q);
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         total_q   <= '0;
         chunk_q   <= '0;
         tmo_q     <= '0;
         rem_q     <= '0;
         off_q     <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         size_q    <= '0;
         wd_q      <= '0;
         rd_seen_q <= 1'b0;
         wr_seen_q <= 1'b0;
         chunks_q  <= '0;
         timeout_q <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (ap_start) begin
                  src_q     <= ctrl_src_addr;
                  dst_q     <= ctrl_dst_addr;
                  total_q   <= ctrl_total_bytes;
                  chunk_q   <= ctrl_chunk_bytes;
                  tmo_q     <= ctrl_timeout_cycles;
                  chunks_q  <= '0;
                  timeout_q <= 1'b0;
                  error_q   <= 1'b0;
                  state_q   <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (misaligned) begin
                  error_q <= 1'b1;
                  state_q <= S_DONE;
               end else if (total_q == '0) begin
                  state_q <= S_DONE;
               end else begin
                  rem_q     <= total_q;
                  off_q     <= '0;
                  rd_addr_q <= src_q;
                  wr_addr_q <= dst_q;
                  size_q    <= chunk_size(chunk_q, total_q);
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wd_q      <= '0;
               rd_seen_q <= 1'b0;
               wr_seen_q <= 1'b0;
               state_q   <= S_WAIT;
            end
            S_WAIT: begin
               if (both_done) begin
                  wd_q      <= '0;
                  rd_seen_q <= 1'b0;
                  wr_seen_q <= 1'b0;
                  state_q   <= S_NEXT;
               end else if (wd_fire) begin
                  wd_q      <= '0;
                  rd_seen_q <= 1'b0;
                  wr_seen_q <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  wd_q      <= wd_inc;
                  rd_seen_q <= rd_hit;
                  wr_seen_q <= wr_hit;
               end
            end
            S_NEXT: begin
               rem_q    <= rem_nxt;
               off_q    <= off_nxt;
               chunks_q <= chunks_q + 32'd1;
               if (rem_nxt == '0) begin
                  state_q <= S_DONE;
               end else begin
                  rd_addr_q <= src_q + off_nxt;
                  wr_addr_q <= dst_q + off_nxt;
                  size_q    <= chunk_size(chunk_q, rem_nxt);
                  state_q   <= S_ISSUE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign ap_done = (state_q == S_DONE);
   assign ap_idle = (state_q == S_IDLE);

   assign rd_ctrl.start              = (state_q == S_ISSUE);
   assign rd_ctrl.addr_offset        = rd_addr_q;
   assign rd_ctrl.xfer_size_in_bytes = size_q;

   assign wr_ctrl.start              = (state_q == S_ISSUE);
   assign wr_ctrl.addr_offset        = wr_addr_q;
   assign wr_ctrl.xfer_size_in_bytes = size_q;

   assign stat_chunks_done = chunks_q;
   assign stat_timeout     = timeout_q;
   assign stat_error       = error_q;

endmodule

// File: tb/tb_axonerve_kvs_batch_sequencer.sv
// Directed bench for the KVS batch sequencer: a table of jobs plus
// hand sequences for stray done pulses and reset in mid-run.
module tb_axonerve_kvs_batch_sequencer;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic [63:0] ctrl_src_addr;
   logic [63:0] ctrl_dst_addr;
   logic [31:0] ctrl_total_bytes;
   logic [31:0] ctrl_chunk_bytes;
   logic [31:0] ctrl_timeout_cycles;
   logic [31:0] stat_chunks_done;
   logic        stat_timeout;
   logic        stat_error;

   axonerve_kvs_batch_sequencer_if #(.ADDR_W(64), .SIZE_W(32)) rd_if ();
   axonerve_kvs_batch_sequencer_if #(.ADDR_W(64), .SIZE_W(32)) wr_if ();

   axonerve_kvs_batch_sequencer #(
      .C_M_AXI_ADDR_WIDTH (64),
      .C_M_AXI_DATA_WIDTH (512),
      .C_XFER_SIZE_WIDTH  (32),
      .C_TIMEOUT_WIDTH    (32)
   ) dut (
      .aclk                (aclk),
      .aresetn             (aresetn),
      .ap_start            (ap_start),
      .ap_done             (ap_done),
      .ap_idle             (ap_idle),
      .ctrl_src_addr       (ctrl_src_addr),
      .ctrl_dst_addr       (ctrl_dst_addr),
      .ctrl_total_bytes    (ctrl_total_bytes),
      .ctrl_chunk_bytes    (ctrl_chunk_bytes),
      .ctrl_timeout_cycles (ctrl_timeout_cycles),
      .rd_ctrl             (rd_if),
      .wr_ctrl             (wr_if),
      .stat_chunks_done    (stat_chunks_done),
      .stat_timeout        (stat_timeout),
      .stat_error          (stat_error)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [63:0] src;
      logic [63:0] dst;
      logic [31:0] total;
      logic [31:0] chunk;
      logic [31:0] tmo;
      int          rd_dly;
      int          wr_dly;
      int          exp_issues;
      int          exp_done;
      int          exp_chunks;
      bit          exp_err;
      bit          exp_tmo;
   } vec_t;

   vec_t vecs[12];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, " ap_done"}, 64'(ap_done), 64'd0);
      chk({nm, " ap_idle"}, 64'(ap_idle), 64'd1);
      chk({nm, " rd_start"}, 64'(rd_if.start), 64'd0);
      chk({nm, " wr_start"}, 64'(wr_if.start), 64'd0);
      chk({nm, " rd_addr"}, rd_if.addr_offset, 64'd0);
      chk({nm, " wr_addr"}, wr_if.addr_offset, 64'd0);
      chk({nm, " rd_size"}, 64'(rd_if.xfer_size_in_bytes), 64'd0);
      chk({nm, " wr_size"}, 64'(wr_if.xfer_size_in_bytes), 64'd0);
      chk({nm, " chunks"}, 64'(stat_chunks_done), 64'd0);
      chk({nm, " timeout"}, 64'(stat_timeout), 64'd0);
      chk({nm, " error"}, 64'(stat_error), 64'd0);
   endtask

   // Cycle 0 is the cycle in which ap_start is high.
   task automatic run_job(input string nm, input vec_t v);
      int          rel;
      int          done_rel;
      int          issues;
      int          rd_due;
      int          wr_due;
      logic [63:0] m_off;
      logic [31:0] m_rem;
      logic [31:0] m_size;
      ctrl_src_addr       = v.src;
      ctrl_dst_addr       = v.dst;
      ctrl_total_bytes    = v.total;
      ctrl_chunk_bytes    = v.chunk;
      ctrl_timeout_cycles = v.tmo;
      ap_start = 1'b1;
      rel      = 0;
      done_rel = -1;
      issues   = 0;
      rd_due   = -1;
      wr_due   = -1;
      m_off    = '0;
      m_rem    = v.total;
      while (rel < 3000 && done_rel < 0) begin
         tick();
         rel++;
         ap_start = (rel == 4);
         if (rel == 1)
            chk({nm, " idle_low"}, 64'(ap_idle), 64'd0);
         if (rel >= 2) begin
            ctrl_src_addr       = 64'hDEAD_0000;
            ctrl_dst_addr       = 64'hBEEF_0000;
            ctrl_total_bytes    = 32'd7;
            ctrl_chunk_bytes    = 32'd3;
            ctrl_timeout_cycles = 32'd1;
         end
         if (rd_if.start) begin
            issues++;
            if (issues == 1)
               chk({nm, " first_issue"}, 64'(rel), 64'd2);
            m_size = (v.chunk == 0 || v.chunk > m_rem) ? m_rem : v.chunk;
            chk({nm, " wr_start"}, 64'(wr_if.start), 64'd1);
            chk({nm, " rd_addr"}, rd_if.addr_offset, v.src + m_off);
            chk({nm, " wr_addr"}, wr_if.addr_offset, v.dst + m_off);
            chk({nm, " rd_size"}, 64'(rd_if.xfer_size_in_bytes),
                64'(m_size));
            chk({nm, " wr_size"}, 64'(wr_if.xfer_size_in_bytes),
                64'(m_size));
            m_off  = m_off + 64'(m_size);
            m_rem  = m_rem - m_size;
            rd_due = (v.rd_dly < 0) ? -1 : rel + v.rd_dly;
            wr_due = (v.wr_dly < 0) ? -1 : rel + v.wr_dly;
         end
         rd_if.done = (rel == rd_due);
         wr_if.done = (rel == wr_due);
         if (ap_done)
            done_rel = rel;
      end
      ap_start   = 1'b0;
      rd_if.done = 1'b0;
      wr_if.done = 1'b0;
      chk({nm, " done_cycle"}, 64'(done_rel), 64'(v.exp_done));
      chk({nm, " issues"}, 64'(issues), 64'(v.exp_issues));
      tick();
      chk({nm, " done_pulse"}, 64'(ap_done), 64'd0);
      chk({nm, " idle_back"}, 64'(ap_idle), 64'd1);
      chk({nm, " chunks"}, 64'(stat_chunks_done), 64'(v.exp_chunks));
      chk({nm, " error"}, 64'(stat_error), 64'(v.exp_err));
      chk({nm, " timeout"}, 64'(stat_timeout), 64'(v.exp_tmo));
   endtask

   initial begin
      int          nissue;
      int          guard;
      bit          saw_done;
      vec_t        v;

      vecs[0]  = '{64'h1000, 64'h8000, 32'd4096, 32'd0, 32'd0,
                   8, 8, 1, 12, 1, 1'b0, 1'b0};
      vecs[1]  = '{64'h0, 64'h20000, 32'd10240, 32'd4096, 32'd0,
                   3, 3, 3, 17, 3, 1'b0, 1'b0};
      vecs[2]  = '{64'h40, 64'h80, 32'd64, 32'd0, 32'd0,
                   7, 2, 1, 11, 1, 1'b0, 1'b0};
      vecs[3]  = '{64'h0, 64'h1000, 32'd128, 32'd64, 32'd0,
                   3, 3, 2, 12, 2, 1'b0, 1'b0};
      vecs[4]  = '{64'h1000, 64'h8000, 32'd0, 32'd0, 32'd0,
                   1, 1, 0, 2, 0, 1'b0, 1'b0};
      vecs[5]  = '{64'h1000, 64'h8000, 32'd100, 32'd0, 32'd0,
                   1, 1, 0, 2, 0, 1'b1, 1'b0};
      vecs[6]  = '{64'h1000, 64'h8000, 32'd4096, 32'd100, 32'd0,
                   1, 1, 0, 2, 0, 1'b1, 1'b0};
      vecs[7]  = '{64'h1000, 64'h8000, 32'd4096, 32'd0, 32'd50,
                   -1, 1, 1, 53, 0, 1'b0, 1'b1};
      vecs[8]  = '{64'h1000, 64'h8000, 32'd4096, 32'd0, 32'd50,
                   5, 5, 1, 9, 1, 1'b0, 1'b0};
      vecs[9]  = '{64'h400, 64'h800, 32'd192, 32'd4096, 32'd0,
                   1, 1, 1, 5, 1, 1'b0, 1'b0};
      vecs[10] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 32'd128, 32'd64,
                   32'd0, 1, 1, 2, 8, 2, 1'b0, 1'b0};
      vecs[11] = '{64'h0, 64'h0, 32'd64, 32'd0, 32'd10,
                   10, 10, 1, 14, 1, 1'b0, 1'b0};

      aresetn             = 1'b0;
      ap_start            = 1'b0;
      ctrl_src_addr       = '0;
      ctrl_dst_addr       = '0;
      ctrl_total_bytes    = '0;
      ctrl_chunk_bytes    = '0;
      ctrl_timeout_cycles = '0;
      rd_if.done          = 1'b0;
      wr_if.done          = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      aresetn = 1'b1;
      tick();

      for (int i = 0; i < 12; i++)
         run_job($sformatf("vec%0d", i), vecs[i]);

      // Stray done pulses while idle must not shorten the next job.
      rd_if.done = 1'b1;
      wr_if.done = 1'b1;
      tick();
      rd_if.done = 1'b0;
      wr_if.done = 1'b0;
      chk("stray idle", 64'(ap_idle), 64'd1);
      tick();
      v = '{64'h2000, 64'h3000, 32'd64, 32'd0, 32'd0,
            6, 3, 1, 10, 1, 1'b0, 1'b0};
      run_job("stray", v);

      // Reset while waiting on the second chunk of a three-chunk job.
      ctrl_src_addr       = 64'h100;
      ctrl_dst_addr       = 64'h200;
      ctrl_total_bytes    = 32'd12288;
      ctrl_chunk_bytes    = 32'd4096;
      ctrl_timeout_cycles = 32'd0;
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      nissue   = 0;
      guard    = 0;
      while (nissue < 2 && guard < 200) begin
         if (rd_if.start)
            nissue++;
         if (nissue == 1 && !rd_if.start) begin
            rd_if.done = 1'b1;
            wr_if.done = 1'b1;
            tick();
            rd_if.done = 1'b0;
            wr_if.done = 1'b0;
         end else if (nissue < 2) begin
            tick();
         end
         guard++;
      end
      chk("rst second_issue", 64'(nissue), 64'd2);
      chk("rst chunk1_count", 64'(stat_chunks_done), 64'd1);
      repeat (2) tick();
      aresetn = 1'b0;
      tick();
      chk_reset_outputs("midrst");
      aresetn  = 1'b1;
      saw_done = 1'b0;
      repeat (20) begin
         tick();
         if (ap_done)
            saw_done = 1'b1;
      end
      chk("midrst no_done", 64'(saw_done), 64'd0);
      chk("midrst idle", 64'(ap_idle), 64'd1);
      run_job("after_rst", vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
